apb_completer_regs: RTL

//  APB completer (slave) answering the CPU's APB master: CPUSEL-decoded transfers arrive as PSEL,
//  8-bit PADDR and 21-bit PWDATA; the block returns PRDATA, PREADY and PSLVERR.
//  It holds a small register file with programmable wait states, and a control register.

---
 rtl/apb_completer_pkg.sv | 16 +
 rtl/apb_reg_array.sv | 30 +++
 rtl/apb_completer_regs.sv | 130 +++++++++++++
 3 files changed

// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB completer register block.
package apb_completer_pkg;

  localparam int unsigned DATA_W = 21;
  localparam int unsigned ADDR_W = 8;

  localparam int unsigned CTRL_PULSE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

endpackage

// File: rtl/apb_reg_array.sv
// Register storage for the APB completer: synchronous write, clear-all, combinational read.
module apb_reg_array #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 21
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        we,
  input  logic                        clear,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr,
  output logic [DATA_W-1:0]           rdata
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with a wait-stated register file and a write-only control register
// that can clear the file and pulse INCPURESET back to the CPU.
module apb_completer_regs #(
  parameter int unsigned             DATA_W      = apb_completer_pkg::DATA_W,
  parameter int unsigned             ADDR_W      = apb_completer_pkg::ADDR_W,
  parameter int unsigned             NUM_REGS    = 16,
  parameter int unsigned             WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0]       CTRL_ADDR   = ADDR_W'(8'hFF)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              INCPURESET
);

  import apb_completer_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  state_e            state_q;
  logic [3:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic              incpureset_q;

  logic              in_range;
  logic              is_ctrl;
  logic              start;
  logic              commit;
  logic              respond;
  logic [DATA_W-1:0] reg_rdata;

  assign in_range = 32'(addr_q) < NUM_REGS;
  assign is_ctrl  = addr_q == CTRL_ADDR;
  assign start    = PSEL && !PENABLE;
  assign commit   = (state_q == ACCESS) && pready_q;

  // PREADY is registered, so the response is loaded one cycle ahead of the PREADY cycle.
  assign respond = ((state_q == SETUP) && PSEL && PENABLE && (wcnt_q == 4'd0)) ||
                   ((state_q == ACCESS) && !pready_q && PSEL && (wcnt_q <= 4'd1));

  apb_reg_array #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regs (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (commit && write_q && in_range),
    .clear   (commit && write_q && is_ctrl && wdata_q[CTRL_CLEAR_BIT]),
    .waddr   (addr_q[IdxW-1:0]),
    .wdata   (wdata_q),
    .raddr   (addr_q[IdxW-1:0]),
    .rdata   (reg_rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      wcnt_q       <= 4'd0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      prdata_q     <= '0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      incpureset_q <= 1'b0;
    end else begin
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
      incpureset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            wcnt_q  <= 4'(WAIT_STATES);
          end
        end
        SETUP: begin
          state_q <= (PSEL && PENABLE) ? ACCESS : IDLE;
        end
        ACCESS: begin
          if (pready_q) begin
            incpureset_q <= write_q && is_ctrl && wdata_q[CTRL_PULSE_BIT];
            // Back-to-back: capture the next transfer on the same edge the old one commits.
            if (start) begin
              state_q <= SETUP;
              addr_q  <= PADDR;
              write_q <= PWRITE;
              wdata_q <= PWDATA;
              wcnt_q  <= 4'(WAIT_STATES);
            end else begin
              state_q <= IDLE;
            end
          end else if (!PSEL) begin
            state_q <= IDLE;
          end else if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (respond) begin
        pready_q  <= 1'b1;
        pslverr_q <= !(in_range || is_ctrl);
        prdata_q  <= (!write_q && in_range) ? reg_rdata : '0;
      end
    end
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign INCPURESET = incpureset_q;

endmodule
